// File: rtl/dbg_commit_queue_pkg.sv
// Shared definitions for the debugger commit path.
// The commit record is the unit the write-back unit retires and the DPI
// bridge consumes; the WBU, this queue and the bridge wrapper all reuse it.
package dbg_commit_queue_pkg;

  localparam int XLEN   = 32;
  localparam int GPR_AW = 5;
  localparam int CSR_AW = 12;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic              gpr_wen;
    logic [GPR_AW-1:0] gpr_waddr;
    logic [XLEN-1:0]   gpr_wdata;
    logic              csr_wen;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              brk;
    logic              ivd;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

  // The bridge takes every register address as a full 32-bit word.
  function automatic logic [XLEN-1:0] zext_gpr(input logic [GPR_AW-1:0] a);
    return {{(XLEN-GPR_AW){1'b0}}, a};
  endfunction

  function automatic logic [XLEN-1:0] zext_csr(input logic [CSR_AW-1:0] a);
    return {{(XLEN-CSR_AW){1'b0}}, a};
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Generic DEPTH-entry synchronous FIFO with full/empty flags.
// Ports:
//   clk, reset (async, active-low)
//   push/wdata : write one entry (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, valid whenever !empty
//   full/empty : occupancy flags from registered pointers only
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // One extra pointer bit tells a full ring apart from an empty one.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries
  // are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dbg_commit_queue.sv
// Commit replay queue between the write-back unit and the debugger DPI
// bridge. Buffers retired-instruction records and replays them in order,
// one per cycle, freezing on the first ebreak / invalid record.
// Ports:
//   clk, reset (async, active-low)
//   in_*   : WBU record with valid/ready handshake
//   out_*  : bridge inputs; pc/inst/addr/data hold, done/wen/brk/ivd pulse
//   halted : sticky stop flag, cleared only by reset
//   retired: number of replayed records (wraps)
module dbg_commit_queue
  import dbg_commit_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_gpr_wen,
  input  logic [4:0]        in_gpr_waddr,
  input  logic [31:0]       in_gpr_wdata,
  input  logic              in_csr_wen,
  input  logic [11:0]       in_csr_waddr,
  input  logic [31:0]       in_csr_wdata,
  input  logic              in_brk,
  input  logic              in_ivd,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_done,
  output logic              out_gpr_wen,
  output logic [31:0]       out_gpr_waddr,
  output logic [31:0]       out_gpr_wdata,
  output logic              out_csr_wen,
  output logic [31:0]       out_csr_waddr,
  output logic [31:0]       out_csr_wdata,
  output logic              out_brk,
  output logic              out_ivd,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  commit_rec_t      in_rec;
  commit_rec_t      head_rec;
  logic [REC_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Last replayed record; its flag bits only reach the outputs while done_q.
  commit_rec_t      rec_q, rec_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign in_rec = '{pc: in_pc, inst: in_inst,
                    gpr_wen: in_gpr_wen, gpr_waddr: in_gpr_waddr, gpr_wdata: in_gpr_wdata,
                    csr_wen: in_csr_wen, csr_waddr: in_csr_waddr, csr_wdata: in_csr_wdata,
                    brk: in_brk, ivd: in_ivd};

  // No ready bypass: a full queue refuses even when it pops this cycle.
  assign in_ready = !fifo_full && !halted_q;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && !halted_q;
  assign head_rec = head_bits;

  commit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_rec),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rec_d     = rec_q;
    done_d    = 1'b0;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (pop) begin
      rec_d     = head_rec;
      done_d    = 1'b1;
      // The halting record itself is still replayed and counted.
      halted_d  = halted_q | head_rec.brk | head_rec.ivd;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_q     <= '0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      rec_q     <= rec_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign out_pc        = rec_q.pc;
  assign out_inst      = rec_q.inst;
  assign out_done      = done_q;
  assign out_gpr_wen   = done_q & rec_q.gpr_wen;
  assign out_gpr_waddr = zext_gpr(rec_q.gpr_waddr);
  assign out_gpr_wdata = rec_q.gpr_wdata;
  assign out_csr_wen   = done_q & rec_q.csr_wen;
  assign out_csr_waddr = zext_csr(rec_q.csr_waddr);
  assign out_csr_wdata = rec_q.csr_wdata;
  assign out_brk       = done_q & rec_q.brk;
  assign out_ivd       = done_q & rec_q.ivd;
  assign halted        = halted_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_dbg_commit_queue.sv
// Directed bench for dbg_commit_queue. A cycle model holds the expected
// queue contents; every clock the full output bus of two instances
// (CNT_W=32 and CNT_W=4) is compared against it.
module tb_dbg_commit_queue;
  import dbg_commit_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic in_valid;
  commit_rec_t cur;

  logic in_ready, out_done, out_gpr_wen, out_csr_wen, out_brk, out_ivd, halted;
  logic [31:0] out_pc, out_inst, out_gpr_waddr, out_gpr_wdata, out_csr_waddr, out_csr_wdata;
  logic [31:0] retired;

  logic in_ready_w, out_done_w, out_gpr_wen_w, out_csr_wen_w, out_brk_w, out_ivd_w, halted_w;
  logic [31:0] out_pc_w, out_inst_w, out_gpr_waddr_w, out_gpr_wdata_w, out_csr_waddr_w, out_csr_wdata_w;
  logic [3:0]  retired_w;

  dbg_commit_queue #(.DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(cur.pc), .in_inst(cur.inst),
    .in_gpr_wen(cur.gpr_wen), .in_gpr_waddr(cur.gpr_waddr), .in_gpr_wdata(cur.gpr_wdata),
    .in_csr_wen(cur.csr_wen), .in_csr_waddr(cur.csr_waddr), .in_csr_wdata(cur.csr_wdata),
    .in_brk(cur.brk), .in_ivd(cur.ivd),
    .out_pc(out_pc), .out_inst(out_inst), .out_done(out_done),
    .out_gpr_wen(out_gpr_wen), .out_gpr_waddr(out_gpr_waddr), .out_gpr_wdata(out_gpr_wdata),
    .out_csr_wen(out_csr_wen), .out_csr_waddr(out_csr_waddr), .out_csr_wdata(out_csr_wdata),
    .out_brk(out_brk), .out_ivd(out_ivd), .halted(halted), .retired(retired)
  );

  dbg_commit_queue #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_pc(cur.pc), .in_inst(cur.inst),
    .in_gpr_wen(cur.gpr_wen), .in_gpr_waddr(cur.gpr_waddr), .in_gpr_wdata(cur.gpr_wdata),
    .in_csr_wen(cur.csr_wen), .in_csr_waddr(cur.csr_waddr), .in_csr_wdata(cur.csr_wdata),
    .in_brk(cur.brk), .in_ivd(cur.ivd),
    .out_pc(out_pc_w), .out_inst(out_inst_w), .out_done(out_done_w),
    .out_gpr_wen(out_gpr_wen_w), .out_gpr_waddr(out_gpr_waddr_w), .out_gpr_wdata(out_gpr_wdata_w),
    .out_csr_wen(out_csr_wen_w), .out_csr_waddr(out_csr_waddr_w), .out_csr_wdata(out_csr_wdata_w),
    .out_brk(out_brk_w), .out_ivd(out_ivd_w), .halted(halted_w), .retired(retired_w)
  );

  logic [198:0] bus_main, bus_c4;
  assign bus_main = {in_ready, out_pc, out_inst, out_done, out_gpr_wen, out_gpr_waddr,
                     out_gpr_wdata, out_csr_wen, out_csr_waddr, out_csr_wdata,
                     out_brk, out_ivd, halted};
  assign bus_c4   = {in_ready_w, out_pc_w, out_inst_w, out_done_w, out_gpr_wen_w, out_gpr_waddr_w,
                     out_gpr_wdata_w, out_csr_wen_w, out_csr_waddr_w, out_csr_wdata_w,
                     out_brk_w, out_ivd_w, halted_w};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / reference model state.
  commit_rec_t mq[$];
  commit_rec_t last;
  logic        m_done;
  logic        m_halted;
  logic [31:0] m_retired;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [198:0] exp_bus();
    logic rdy;
    rdy = (mq.size() < DEPTH) && !m_halted;
    return {rdy, last.pc, last.inst, m_done, m_done & last.gpr_wen,
            {27'b0, last.gpr_waddr}, last.gpr_wdata, m_done & last.csr_wen,
            {20'b0, last.csr_waddr}, last.csr_wdata,
            m_done & last.brk, m_done & last.ivd, m_halted};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_bus"}, bus_main, exp_bus());
    check({tag, "_bus_c4"}, bus_c4, exp_bus());
    check({tag, "_retired"}, retired, m_retired);
    check({tag, "_retired_c4"}, retired_w, m_retired[3:0]);
  endtask

  // One clock: predict pop/push from pre-edge model state, then compare.
  task automatic tick();
    logic m_pop, m_push;
    commit_rec_t pushed;
    pushed = cur;
    m_pop  = (mq.size() != 0) && !m_halted;
    m_push = in_valid && (mq.size() < DEPTH) && !m_halted;
    @(posedge clk);
    #1;
    m_done = m_pop;
    if (m_pop) begin
      last = mq.pop_front();
      m_retired++;
      if (last.brk || last.ivd) m_halted = 1'b1;
    end
    if (m_push) mq.push_back(pushed);
    check_all("tick");
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    mq.delete();
    last      = '0;
    m_done    = 1'b0;
    m_halted  = 1'b0;
    m_retired = '0;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    reset = 1'b1;
  endtask

  function automatic commit_rec_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                     input logic gw, input logic [4:0] ga, input logic [31:0] gd,
                                     input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                                     input logic b, input logic v);
    commit_rec_t r;
    r = '{pc: pc, inst: inst, gpr_wen: gw, gpr_waddr: ga, gpr_wdata: gd,
          csr_wen: cw, csr_waddr: ca, csr_wdata: cd, brk: b, ivd: v};
    return r;
  endfunction

  initial begin
    cur      = '0;
    in_valid = 1'b0;
    reset    = 1'b0;
    do_reset();
    check("reset_ready", in_ready, 1'b1);

    // Single record: accepted at edge k, replayed at edge k+1.
    cur = mk(32'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 32'd1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    check("single_no_early_done", out_done, 1'b0);
    in_valid = 1'b0;
    tick();
    check("single_done", out_done, 1'b1);
    check("single_waddr", out_gpr_waddr, 32'h0000_0001);
    tick();
    check("single_done_drop", out_done, 1'b0);
    check("single_pc_hold", out_pc, 32'h8000_0000);

    // Eight back-to-back records, in_valid held high.
    for (int i = 0; i < 8; i++) begin
      cur = mk(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), i[0], 5'(i + 3), 32'(i * 7),
               i[1], 12'(12'h300 + i), 32'hC000_0000 | 32'(i), 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      check("b2b_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("b2b_retired", retired, 32'd9);

    // Reset mid-stream: pending entries are discarded, nothing replays.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cur = mk(32'h200 + 32'(i * 4), 32'h13, 1'b1, 5'(i + 1), 32'(i), 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    check("midrst_done", out_done, 1'b0);
    check("midrst_retired", retired, 32'd0);
    check("midrst_ready", in_ready, 1'b1);

    // Halt on ebreak; the following record stays queued forever.
    cur = mk(32'h10, 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    cur = mk(32'h14, 32'h0010_0073, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
    tick();
    cur = mk(32'h18, 32'h3050_1073, 1'b0, 5'd0, 32'h0, 1'b1, 12'h305, 32'h55, 1'b0, 1'b0);
    tick();
    check("halt_brk_pulse", out_brk, 1'b1);
    check("halt_pc", out_pc, 32'h14);
    cur = mk(32'h1c, 32'h13, 1'b1, 5'd9, 32'h9, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("halt_flag", halted, 1'b1);
    check("halt_ready", in_ready, 1'b0);
    check("halt_retired", retired, 32'd2);
    check("halt_pc_hold", out_pc, 32'h14);

    // A record flagged both brk and ivd pulses both outputs.
    do_reset();
    cur = mk(32'h40, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h1234, 1'b1, 12'hFFF, 32'h5678, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("both_brk", out_brk, 1'b1);
    check("both_ivd", out_ivd, 1'b1);
    check("both_csr_waddr", out_csr_waddr, 32'h0000_0FFF);
    tick();
    check("both_halted", halted, 1'b1);

    // Counter wrap on the CNT_W=4 instance after 17 replays.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cur = mk(32'h1000 + 32'(i * 4), 32'(i), 1'b1, 5'(i), 32'(i), 1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("wrap_c4", retired_w, 4'd1);
    check("wrap_c32", retired, 32'd17);

    // Irregular valid pattern with random payloads: order and count kept.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cur.pc        = $urandom();
      cur.inst      = $urandom();
      cur.gpr_wen   = 1'($urandom());
      cur.gpr_waddr = 5'($urandom());
      cur.gpr_wdata = $urandom();
      cur.csr_wen   = 1'($urandom());
      cur.csr_waddr = 12'($urandom());
      cur.csr_wdata = $urandom();
      cur.brk       = 1'b0;
      cur.ivd       = 1'b0;
      in_valid      = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("rand_drained", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
